// File: rtl/actel_s2_cfg_array_if.sv
// Bus bundle for the S2 cell array: select inputs, enable, config chain and status/outputs.
interface actel_s2_cfg_array_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic             en;
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_din;
  logic             cfg_busy;
  logic             cfg_done;
  logic             configured;
  logic [WIDTH-1:0] out;

  // Driver side: supplies cell inputs and the serial configuration stream.
  modport master (
    output A1, B1, A0, B0, en, cfg_start, cfg_valid, cfg_din,
    input  cfg_busy, cfg_done, configured, out
  );

  // Array side.
  modport slave (
    input  A1, B1, A0, B0, en, cfg_start, cfg_valid, cfg_din,
    output cfg_busy, cfg_done, configured, out
  );
endinterface

// File: rtl/actel_s2_cfg_array.sv
// Array of WIDTH Actel S2-style cells with a serially loaded, shadow-buffered configuration.
module actel_s2_cfg_array #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  actel_s2_cfg_array_if.slave  bus
);

  localparam int unsigned CELL_BITS = 5;
  localparam int unsigned CFG_BITS  = CELL_BITS * WIDTH;
  localparam int unsigned CNT_W     = $clog2(CFG_BITS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CFG_BITS-1:0]   shadow_q, shadow_d;
  logic [CFG_BITS-1:0]   active_q, active_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  done_q, done_d;
  logic                  configured_q, configured_d;

  logic [WIDTH-1:0]      f_c;
  logic [WIDTH-1:0]      mode_c;
  logic [CELL_BITS-1:0]  cell_c;
  logic [1:0]            sel_c;

  // Per-cell select logic and table lookup against the active configuration.
  always_comb begin
    f_c    = '0;
    mode_c = '0;
    cell_c = '0;
    sel_c  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cell_c = active_q[i*CELL_BITS +: CELL_BITS];
      sel_c  = {bus.A1[i] | bus.B1[i], bus.A0[i] & bus.B0[i]};
      case (sel_c)
        2'b00:   f_c[i] = cell_c[0];
        2'b01:   f_c[i] = cell_c[1];
        2'b10:   f_c[i] = cell_c[2];
        default: f_c[i] = cell_c[3];
      endcase
      mode_c[i] = cell_c[4];
    end
  end

  // Configuration loader: restart wins over data, last accepted bit commits shadow to active.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    done_d       = 1'b0;
    configured_d = configured_q;
    if (bus.cfg_start) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (state_q == SHIFT && bus.cfg_valid) begin
      shadow_d[cnt_q] = bus.cfg_din;
      if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
        active_d     = shadow_d;
        state_d      = IDLE;
        cnt_d        = '0;
        done_d       = 1'b1;
        configured_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Cell output flops; not cleared on commit so a cell switching to registered mode keeps its q.
  always_comb begin
    q_d = bus.en ? f_c : q_q;
  end

  // State registers with synchronous clear taking priority over everything else.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      q_q          <= '0;
      done_q       <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      q_q          <= q_d;
      done_q       <= done_d;
      configured_q <= configured_d;
    end
  end

  // Output select: registered cells present q, combinational cells present the lookup directly.
  assign bus.out        = (mode_c & q_q) | (~mode_c & f_c);
  assign bus.cfg_busy   = (state_q == SHIFT);
  assign bus.cfg_done   = done_q;
  assign bus.configured = configured_q;

endmodule

// File: tb/tb_actel_s2_cfg_array.sv
// Directed bench for the S2 cell array, WIDTH = 2 (10 configuration bits).
module tb_actel_s2_cfg_array;

  localparam int unsigned W = 2;
  // cell0: D=0,1,1,0 comb (XOR of S1,S0); cell1: D=0,0,0,1 registered (AND)
  localparam logic [9:0] CFG_XOR_AND = 10'h306;
  // both cells all-ones tables, combinational
  localparam logic [9:0] CFG_ONES    = 10'h1EF;
  localparam logic [9:0] CFG_ALL     = 10'h3FF;

  logic CLK = 1'b0;
  logic CLR;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  actel_s2_cfg_array_if #(.WIDTH(W)) bus ();

  actel_s2_cfg_array #(.WIDTH(W)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [1:0] a1, input logic [1:0] b1,
                        input logic [1:0] a0, input logic [1:0] b0);
    bus.A1 = a1; bus.B1 = b1; bus.A0 = a0; bus.B0 = b0;
    #1;
  endtask

  task automatic start_load();
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b0;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    bus.cfg_valid = 1'b1;
    bus.cfg_din   = b;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.A1 = W'($urandom); bus.B1 = W'($urandom);
      bus.A0 = W'($urandom); bus.B0 = W'($urandom);
      bus.en = 1'($urandom); bus.cfg_start = 1'($urandom);
      bus.cfg_valid = 1'($urandom); bus.cfg_din = 1'($urandom);
      tick();
    end
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.en = 1'b1;
    #1;
    n_tests++; if (bus.out !== 2'b00) begin n_fail++; $display("FAIL reset_out: got %b exp 00", bus.out); end
    n_tests++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.cfg_busy); end
    n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.cfg_done); end
    n_tests++; if (bus.configured !== 1'b0) begin n_fail++; $display("FAIL reset_configured: got %b exp 0", bus.configured); end
    CLR = 1'b0;
    for (int c = 0; c < 256; c++) begin
      logic [7:0] v;
      v = 8'(c);
      set_in(v[7:6], v[5:4], v[3:2], v[1:0]);
      n_tests++; if (bus.out !== 2'b00) begin n_fail++; $display("FAIL unconfigured_out: in=%h got %b exp 00", v, bus.out); end
      tick();
    end
  endtask

  task automatic test_xor_load();
    logic [9:0] cfg;
    cfg = CFG_XOR_AND;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    start_load();
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (bus.cfg_busy !== 1'b1 || bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL xor_loading k=%0d: busy=%b done=%b exp busy=1 done=0", k, bus.cfg_busy, bus.cfg_done); end
      shift_bit(cfg[k]);
    end
    n_tests++; if (bus.cfg_done !== 1'b1) begin n_fail++; $display("FAIL xor_done: got %b exp 1", bus.cfg_done); end
    n_tests++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL xor_busy_drop: got %b exp 0", bus.cfg_busy); end
    n_tests++; if (bus.configured !== 1'b1) begin n_fail++; $display("FAIL xor_configured: got %b exp 1", bus.configured); end
    tick();
    n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL xor_done_pulse: got %b exp 0", bus.cfg_done); end
    // cell0 combinational XOR of S1,S0
    set_in(2'b00, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b1) begin n_fail++; $display("FAIL xor_s01: got %b exp 1", bus.out[0]); end
    set_in(2'b01, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b0) begin n_fail++; $display("FAIL xor_s11: got %b exp 0", bus.out[0]); end
    set_in(2'b01, 2'b00, 2'b00, 2'b00);
    n_tests++; if (bus.out[0] !== 1'b1) begin n_fail++; $display("FAIL xor_s10: got %b exp 1", bus.out[0]); end
    // cell1 registered AND: one cycle latency
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    set_in(2'b10, 2'b00, 2'b10, 2'b10);
    n_tests++; if (bus.out !== 2'b00) begin n_fail++; $display("FAIL and_before_edge: got %b exp 00", bus.out); end
    tick();
    n_tests++; if (bus.out !== 2'b10) begin n_fail++; $display("FAIL and_after_edge: got %b exp 10", bus.out); end
  endtask

  task automatic test_stall_enable();
    logic [9:0] cfg;
    cfg = CFG_XOR_AND;
    CLR = 1'b1; tick(); CLR = 1'b0;
    n_tests++; if (bus.configured !== 1'b0) begin n_fail++; $display("FAIL stall_clr_configured: got %b exp 0", bus.configured); end
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    start_load();
    for (int k = 0; k < 10; k++) begin
      if (k == 2 || k == 5 || k == 8) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_din   = 1'b1;
        tick();
        n_tests++; if (bus.cfg_done !== 1'b0 || bus.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL stall_gap k=%0d: done=%b busy=%b exp done=0 busy=1", k, bus.cfg_done, bus.cfg_busy); end
      end
      shift_bit(cfg[k]);
      if (k < 9) begin
        n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL stall_early_done k=%0d: got %b exp 0", k, bus.cfg_done); end
      end
    end
    n_tests++; if (bus.cfg_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b exp 1", bus.cfg_done); end
    set_in(2'b00, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b1) begin n_fail++; $display("FAIL stall_xor: got %b exp 1", bus.out[0]); end
    // enable: capture 1 on cell1, then hold it while inputs toggle with en=0
    set_in(2'b10, 2'b00, 2'b10, 2'b10);
    bus.en = 1'b1;
    tick();
    n_tests++; if (bus.out[1] !== 1'b1) begin n_fail++; $display("FAIL en_capture: got %b exp 1", bus.out[1]); end
    bus.en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_in(2'b00, 2'b00, (j % 2 == 0) ? 2'b00 : 2'b10, 2'b10);
      tick();
      n_tests++; if (bus.out[1] !== 1'b1) begin n_fail++; $display("FAIL en_hold j=%0d: got %b exp 1", j, bus.out[1]); end
    end
    bus.en = 1'b1;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    n_tests++; if (bus.out[1] !== 1'b0) begin n_fail++; $display("FAIL en_resume: got %b exp 0", bus.out[1]); end
  endtask

  task automatic test_shadow_isolation();
    logic [9:0] cfg;
    cfg = CFG_ONES;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    start_load();
    for (int k = 0; k < 5; k++) shift_bit(cfg[k]);
    n_tests++; if (bus.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL shadow_busy: got %b exp 1", bus.cfg_busy); end
    set_in(2'b00, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b1) begin n_fail++; $display("FAIL shadow_xor_s01: got %b exp 1", bus.out[0]); end
    set_in(2'b01, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b0) begin n_fail++; $display("FAIL shadow_xor_s11: got %b exp 0", bus.out[0]); end
    set_in(2'b10, 2'b00, 2'b10, 2'b10);
    tick();
    n_tests++; if (bus.out[1] !== 1'b1) begin n_fail++; $display("FAIL shadow_and_s11: got %b exp 1", bus.out[1]); end
    set_in(2'b10, 2'b00, 2'b00, 2'b00);
    tick();
    n_tests++; if (bus.out[1] !== 1'b0) begin n_fail++; $display("FAIL shadow_and_s10: got %b exp 0", bus.out[1]); end
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 5; k < 10; k++) shift_bit(cfg[k]);
    n_tests++; if (bus.cfg_done !== 1'b1) begin n_fail++; $display("FAIL shadow_done: got %b exp 1", bus.cfg_done); end
    for (int c = 0; c < 256; c++) begin
      logic [7:0] v;
      v = 8'(c);
      set_in(v[7:6], v[5:4], v[3:2], v[1:0]);
      n_tests++; if (bus.out !== 2'b11) begin n_fail++; $display("FAIL ones_out: in=%h got %b exp 11", v, bus.out); end
    end
  endtask

  task automatic test_restart();
    logic [9:0] junk;
    logic [9:0] cfg;
    junk = CFG_ALL;
    cfg  = CFG_XOR_AND;
    bus.en = 1'b1;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    start_load();
    for (int k = 0; k < 6; k++) begin
      shift_bit(junk[k]);
      n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_first_done k=%0d: got %b exp 0", k, bus.cfg_done); end
    end
    // restart with a valid bit in the same cycle: that bit must be dropped
    bus.cfg_start = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_din = 1'b1;
    tick();
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
    n_tests++; if (bus.cfg_busy !== 1'b1 || bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_state: busy=%b done=%b exp busy=1 done=0", bus.cfg_busy, bus.cfg_done); end
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_early_done k=%0d: got %b exp 0", k, bus.cfg_done); end
      shift_bit(cfg[k]);
    end
    n_tests++; if (bus.cfg_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b exp 1", bus.cfg_done); end
    // cell1 now registered, presenting q captured under the old all-ones table
    n_tests++; if (bus.out !== 2'b10) begin n_fail++; $display("FAIL restart_q_kept: got %b exp 10", bus.out); end
    tick();
    n_tests++; if (bus.cfg_done !== 1'b0 || bus.out !== 2'b00) begin n_fail++; $display("FAIL restart_after: done=%b out=%b exp done=0 out=00", bus.cfg_done, bus.out); end
    tick();
    n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_single_pulse: got %b exp 0", bus.cfg_done); end
    set_in(2'b01, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b0) begin n_fail++; $display("FAIL restart_xor_s11: got %b exp 0", bus.out[0]); end
    set_in(2'b00, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out[0] !== 1'b1) begin n_fail++; $display("FAIL restart_xor_s01: got %b exp 1", bus.out[0]); end
    set_in(2'b10, 2'b00, 2'b10, 2'b10);
    tick();
    n_tests++; if (bus.out[1] !== 1'b1) begin n_fail++; $display("FAIL restart_and_s11: got %b exp 1", bus.out[1]); end
    set_in(2'b10, 2'b00, 2'b00, 2'b00);
    tick();
    n_tests++; if (bus.out[1] !== 1'b0) begin n_fail++; $display("FAIL restart_and_s10: got %b exp 0", bus.out[1]); end
  endtask

  task automatic test_clr_mid_shift();
    logic [9:0] junk;
    logic [9:0] cfg;
    junk = CFG_ALL;
    cfg  = CFG_ONES;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    start_load();
    for (int k = 0; k < 4; k++) shift_bit(junk[k]);
    CLR = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_din = 1'b1; bus.cfg_start = 1'b1;
    tick();
    CLR = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_start = 1'b0;
    n_tests++; if (bus.configured !== 1'b0) begin n_fail++; $display("FAIL clr_configured: got %b exp 0", bus.configured); end
    n_tests++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b exp 0", bus.cfg_busy); end
    n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL clr_done: got %b exp 0", bus.cfg_done); end
    set_in(2'b11, 2'b11, 2'b11, 2'b11);
    n_tests++; if (bus.out !== 2'b00) begin n_fail++; $display("FAIL clr_out_ones: got %b exp 00", bus.out); end
    set_in(2'b00, 2'b00, 2'b01, 2'b01);
    n_tests++; if (bus.out !== 2'b00) begin n_fail++; $display("FAIL clr_out_s01: got %b exp 00", bus.out); end
    // remaining bits arrive while idle and must be ignored
    for (int k = 4; k < 10; k++) begin
      shift_bit(junk[k]);
      n_tests++; if (bus.cfg_done !== 1'b0 || bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle_bits k=%0d: done=%b busy=%b exp 0 0", k, bus.cfg_done, bus.cfg_busy); end
    end
    start_load();
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL clr_reload_early k=%0d: got %b exp 0", k, bus.cfg_done); end
      shift_bit(cfg[k]);
    end
    n_tests++; if (bus.cfg_done !== 1'b1 || bus.configured !== 1'b1) begin n_fail++; $display("FAIL clr_reload_done: done=%b configured=%b exp 1 1", bus.cfg_done, bus.configured); end
    set_in(2'b01, 2'b10, 2'b00, 2'b11);
    n_tests++; if (bus.out !== 2'b11) begin n_fail++; $display("FAIL clr_reload_out: got %b exp 11", bus.out); end
  endtask

  initial begin
    CLR = 1'b1;
    bus.A1 = '0; bus.B1 = '0; bus.A0 = '0; bus.B0 = '0;
    bus.en = 1'b1; bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_din = 1'b0;
    test_reset();
    test_xor_load();
    test_stall_enable();
    test_shadow_isolation();
    test_restart();
    test_clr_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/actel_s2_cfg_array.md
# actel_s2_cfg_array

Parametrised successor to the single Actel S2-style logic module. The block holds WIDTH independent S2 cells with the same select logic: S0 = A0 & B0, S1 = A1 | B1, and out = D[{S1,S0}]. The per-cell truth table (D00..D11) and output mode (registered or combinational) come from a serial configuration chain rather than from ports. New configuration loads into a shadow register while the array keeps running on the old one, then commits in a single cycle, so the cells behave as a reconfigurable logic tile in the CA2 fabric experiments.

## Interface
- WIDTH, 8: number of S2 cells; must be ≥ 1.
- CFG_BITS, 5*WIDTH: derived, not overridable; total configuration bits.
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset; synchronous, active-high.
- A1, B1, A0, B0  in  WIDTH  per-cell select inputs; bit i drives cell i.
- en  in  1  clock enable for the per-cell output flip-flops.
- cfg_start  in  1  begin or restart a configuration load.
- cfg_valid  in  1  cfg_din is valid this cycle.
- cfg_din  in  1  serial configuration bit.
- cfg_busy  out  1  high while in the SHIFT state.
- cfg_done  out  1  one-cycle pulse after a commit.
- configured  out  1  high once any configuration has committed since CLR.
- out  out  WIDTH  cell outputs.

## Operation
- Configuration layout (bit k is the k-th accepted bit, k = 0 first). Cell i occupies k = 5i..5i+4 in this order: D00, D01, D10, D11, MODE.
- MODE = 1 selects the registered output; MODE = 0 selects the combinational output.
- Per cell: f[i] = D{S1,S0}[i] from the active config. out[i] = MODE[i] ? q[i] : f[i].
- q[i] updates on each edge: 0 if CLR; f[i] if en; otherwise it holds.
- FSM states:
  - IDLE: no load in progress.
  - SHIFT: load in progress.
- FSM transitions:
  - Any state with cfg_start=1 goes to SHIFT, and the bit counter clears to 0.
  - In SHIFT, each cycle with cfg_valid=1 writes cfg_din to shadow[cnt] and increments cnt. cfg_valid=0 stalls with no change.
  - SHIFT with cfg_valid=1 and cnt = CFG_BITS−1 is the commit: at that edge, active ← shadow (including the final bit), state goes to IDLE, and configured ← 1.
  - cfg_start and cfg_valid in the same cycle: the restart wins, and that cycle's bit is discarded.
- Until the commit, the active config is unchanged. Cells keep evaluating with the old table and mode throughout SHIFT.
- At commit, q is not cleared. A cell switching to registered mode presents its existing q.
- Counter width is $clog2(CFG_BITS+1); cnt never exceeds CFG_BITS−1.
- CLR response:
  - State → IDLE, cnt → 0, shadow and active → all zeros, q → 0.
  - cfg_done → 0, configured → 0.
  - CLR overrides cfg_start, cfg_valid and en in the same cycle.
- While unconfigured the active config is all zero, so out = 0 for all input values.

## Timing
- Reset values: out = 0, cfg_busy = 0, cfg_done = 0, configured = 0.
- Combinational cell: out follows A/B in the same cycle (zero latency).
- Registered cell: out reflects inputs sampled at the previous edge where en=1 (1-cycle latency).
- cfg_busy is high in the cycle after cfg_start is sampled, and drops in the cycle after the commit edge.
- cfg_done is high for exactly the one cycle after the commit edge, the same cycle in which the new config first takes effect.
- Minimum load time is CFG_BITS cycles after cfg_start; each cycle with cfg_valid=0 adds one cycle.
- A CLR mid-SHIFT aborts the load; no commit occurs and cfg_done stays 0.

## Test plan
- Reset: hold CLR for 2 cycles with random inputs → out = 0, cfg_busy = 0, configured = 0. With no config, drive all input combinations → out stays 0.
- XOR load, WIDTH=2: cfg_start, then bits 0,1,1,0,0 for cell0 (combinational XOR of S1,S0) and 0,0,0,1,1 for cell1 (registered AND).
  - cfg_done pulses 10 cycles after cfg_start.
  - Cell0 with A0=B0=1, A1=B1=0 → out[0]=1 in the same cycle.
  - Cell1 with A0=B0=A1=1 → out[1]=1 one cycle later.
- Enable and stall gaps: same load with cfg_valid=0 on 3 random cycles → commit delayed by 3 cycles, identical result. With en=0 on the registered cell → out[1] holds while its inputs toggle.
- Shadow isolation: with the config above running, start a load of all-ones tables. Mid-SHIFT, out still matches XOR/AND; after the commit, out = 1 for all inputs on both cells.
- Restart: cfg_start at bit 6 of a load, then a full new 10-bit load → only the second config is committed, and cfg_done pulses once.
- CLR mid-SHIFT at bit 4 → no cfg_done pulse, out = 0, configured = 0. A following full load commits normally.
